bm1387_host_cmd_master: RTL
===========================

Name: bm1387_host_cmd_master

Overview:
Host/firmware-side command initiator for the BM1387 ASIC UART link; it is the requesting end of the status, temperature, hash-rate and reset commands that the ASIC-side interface answers.
- Takes one command request and frames it into 4 bytes.
- Pushes those bytes to a byte-level UART transmitter using a valid/ready handshake.
- Collects the 5-byte response from a byte-level UART receiver, checks it, and returns data plus a status code.
- Sits between the firmware model / testbench driver and the UART byte serializers.

Parameters:
TIMEOUT_CYCLES, 100000, response window in clk cycles, counted from acceptance of the last request byte.
TMO_W, 17, timeout counter width; must satisfy 2^TMO_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  command request valid
req_ready  out  1  high only in IDLE
req_cmd  in  8  command code (0x01 status, 0x02 temp, 0x03 hashrate, 0x04 reset)
req_arg  in  8  command argument
tx_byte  out  8  byte to UART transmitter
tx_byte_valid  out  1  tx_byte valid
tx_byte_ready  in  1  transmitter accepts byte
rx_byte  in  8  byte from UART receiver
rx_byte_valid  in  1  one-cycle strobe per received byte
rsp_valid  out  1  one-cycle response pulse
rsp_cmd  out  8  command echoed in response
rsp_data  out  16  response payload {hi, lo}
rsp_status  out  2  00 ok, 01 timeout, 10 checksum error, 11 command mismatch
busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: clk; reset reset_n, asynchronous, active-low.
- Reset values: req_ready=1, busy=0, tx_byte_valid=0, tx_byte=0x00, rsp_valid=0, rsp_cmd=0x00, rsp_data=0x0000, rsp_status=00. State goes to IDLE.
- Request frame: 0x55, cmd, arg, chk. chk = cmd ^ arg.
- Response frame: 0xAA, cmd, hi, lo, chk. chk = cmd ^ hi ^ lo.
- States: IDLE, SEND, WAIT_HDR, RX_BODY, DONE.
- IDLE:
  - On req_valid && req_ready, latch cmd and arg, set byte index to 0, go to SEND.
  - rx bytes arriving in IDLE are discarded.
- SEND:
  - tx_byte_valid=1 and tx_byte=frame[idx], registered outputs.
  - tx_byte and tx_byte_valid hold stable until tx_byte_ready.
  - On each handshake idx increments. The handshake on idx 3 goes to WAIT_HDR and clears the timer.
  - rx bytes arriving in SEND are discarded.
- WAIT_HDR:
  - Timer increments every cycle.
  - Any rx byte other than 0xAA is discarded.
  - 0xAA goes to RX_BODY with body index 0.
- RX_BODY:
  - Timer keeps counting; it is not reset by received bytes.
  - Body bytes are stored in order as cmd, hi, lo, chk.
  - After the 4th body byte, go to DONE.
- Timeout:
  - When the timer reaches TIMEOUT_CYCLES-1 in WAIT_HDR or RX_BODY, go to DONE with status 01, rsp_data=0, rsp_cmd=latched cmd.
  - If the final body byte arrives in the same cycle as expiry, the byte wins and the frame is evaluated normally.
- DONE:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - Status priority: checksum error (10) > command mismatch (11) > ok (00).
  - rsp_cmd and rsp_data carry the received values even on error.
  - Outputs hold until the next DONE.
- Latency:
  - First tx_byte_valid appears 1 cycle after request acceptance.
  - rsp_valid appears 1 cycle after the strobe of the final body byte.
  - rsp_valid appears exactly TIMEOUT_CYCLES+1 cycles after the last tx handshake on timeout.
- Reset mid-operation: immediate return to IDLE; the partial frame is abandoned and tx_byte_valid drops asynchronously.
- Only one outstanding command at a time; no queueing.

Optional Feature:
BM1387_HOST_STATS_EN.
- Defined:
  - Adds ports err_timeout_cnt (out, 16) and err_chk_cnt (out, 16).
  - Each is a saturating counter at 0xFFFF, incremented on a DONE with status 01 or 10 respectively.
  - Both reset to 0.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package bm1387_host_pkg:
  - SYNC_REQ=0x55, SYNC_RSP=0xAA.
  - Command code constants.
  - rsp_status enum.
  - State enum.
- One sub-module, host_timeout_timer: clear/enable inputs, expired output, parameterised by TIMEOUT_CYCLES and TMO_W.

Test Plan:
- Normal response: req 0x02/0x00 with tx_byte_ready=1 -> tx bytes 55 02 00 02. Then feed AA 02 01 2C 2F -> rsp_valid pulse, rsp_data=0x012C, rsp_cmd=0x02, status 00.
- Bad checksum: req 0x01. Feed AA 01 00 05 00 -> status 10, rsp_data=0x0005. With BM1387_HOST_STATS_EN, err_chk_cnt=1.
- Timeout: TIMEOUT_CYCLES=50, req 0x03, no rx -> rsp_valid 51 cycles after the 4th tx handshake, status 01, rsp_data=0.
- Leading garbage: req 0x03. Feed 00 FF AA 03 12 34 25 -> status 00, rsp_data=0x1234.
- Command mismatch and backpressure: req 0x03 with tx_byte_ready low for 5 cycles on byte 2 -> tx_byte held at 0x00, no byte skipped. Then feed AA 01 00 00 01 -> status 11.
- Reset mid-SEND: assert reset_n=0 after byte 1 -> tx_byte_valid=0, req_ready=1, busy=0. A new req 0x04 then starts cleanly with 55 04 ...

Source files
------------

// File: rtl/bm1387_host_pkg.sv
// BM1387 host command master: shared frame constants, status codes and states.
// Optional error counters are enabled with BM1387_HOST_STATS_EN.
package bm1387_host_pkg;

    localparam logic [7:0] SYNC_REQ = 8'h55;
    localparam logic [7:0] SYNC_RSP = 8'hAA;

    localparam logic [7:0] CMD_STATUS   = 8'h01;
    localparam logic [7:0] CMD_TEMP     = 8'h02;
    localparam logic [7:0] CMD_HASHRATE = 8'h03;
    localparam logic [7:0] CMD_RESET    = 8'h04;

    typedef enum logic [1:0] {
        RSP_OK      = 2'b00,
        RSP_TIMEOUT = 2'b01,
        RSP_CHK_ERR = 2'b10,
        RSP_CMD_ERR = 2'b11
    } rsp_status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_HDR,
        S_RX_BODY,
        S_DONE
    } state_e;

    // Request frame byte at position idx: sync, cmd, arg, cmd^arg.
    function automatic logic [7:0] req_byte(
        input logic [1:0] idx,
        input logic [7:0] cmd,
        input logic [7:0] arg
    );
        logic [7:0] b;
        unique case (idx)
            2'd0:    b = SYNC_REQ;
            2'd1:    b = cmd;
            2'd2:    b = arg;
            default: b = cmd ^ arg;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/bm1387_host_cmd_master_timer.sv
// Response-window timer: cleared at end of request, counts while enabled,
// flags the last cycle of the window.
module host_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TMO_W          = 17
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == LAST);
    assign o_expired = i_enable && w_at_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (i_enable && !w_at_last)
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/bm1387_host_cmd_master.sv
// BM1387 host command master: frames a request, sends it byte-wise, collects and checks the reply.
// Define BM1387_HOST_STATS_EN to add saturating timeout/checksum error counters.
module bm1387_host_cmd_master
    import bm1387_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TMO_W          = 17
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd,
    input  logic [7:0]  req_arg,
    output logic [7:0]  tx_byte,
    output logic        tx_byte_valid,
    input  logic        tx_byte_ready,
    input  logic [7:0]  rx_byte,
    input  logic        rx_byte_valid,
    output logic        rsp_valid,
    output logic [7:0]  rsp_cmd,
    output logic [15:0] rsp_data,
    output logic [1:0]  rsp_status,
`ifdef BM1387_HOST_STATS_EN
    output logic [15:0] err_timeout_cnt,
    output logic [15:0] err_chk_cnt,
`endif
    output logic        busy
);

    state_e      r_state, w_next;
    logic [7:0]  r_cmd, r_arg;
    logic [1:0]  r_idx, r_bidx;
    logic [7:0]  r_rx_cmd, r_rx_hi, r_rx_lo;
    logic        w_tx_hs, w_last_hs, w_rx_last;
    logic        w_tmo_en, w_expired, w_timeout;
    logic        w_chk_bad;
    rsp_status_e w_rx_status;

    assign w_tx_hs   = tx_byte_valid && tx_byte_ready;
    assign w_last_hs = (r_state == S_SEND) && w_tx_hs && (r_idx == 2'd3);
    assign w_rx_last = (r_state == S_RX_BODY) && rx_byte_valid && (r_bidx == 2'd3);
    assign w_tmo_en  = (r_state == S_WAIT_HDR) || (r_state == S_RX_BODY);
    // A final body byte landing on the expiry cycle still completes the frame.
    assign w_timeout = w_expired && !w_rx_last;
    assign w_chk_bad = (r_rx_cmd ^ r_rx_hi ^ r_rx_lo) != rx_byte;

    always_comb begin
        w_rx_status = RSP_OK;
        if (w_chk_bad)
            w_rx_status = RSP_CHK_ERR;
        else if (r_rx_cmd != r_cmd)
            w_rx_status = RSP_CMD_ERR;
    end

    host_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TMO_W         (TMO_W)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clear  (w_last_hs),
        .i_enable (w_tmo_en),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:     if (req_valid) w_next = S_SEND;
            S_SEND:     if (w_last_hs) w_next = S_WAIT_HDR;
            S_WAIT_HDR: begin
                if (w_expired)
                    w_next = S_DONE;
                else if (rx_byte_valid && rx_byte == SYNC_RSP)
                    w_next = S_RX_BODY;
            end
            S_RX_BODY:  if (w_rx_last || w_expired) w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_byte_valid <= 1'b0;
            tx_byte       <= 8'h00;
            rsp_valid     <= 1'b0;
            rsp_cmd       <= 8'h00;
            rsp_data      <= 16'h0000;
            rsp_status    <= RSP_OK;
            r_cmd         <= 8'h00;
            r_arg         <= 8'h00;
            r_idx         <= 2'd0;
            r_bidx        <= 2'd0;
            r_rx_cmd      <= 8'h00;
            r_rx_hi       <= 8'h00;
            r_rx_lo       <= 8'h00;
        end else begin
            rsp_valid <= 1'b0;
            if (r_state == S_IDLE && req_valid) begin
                r_cmd         <= req_cmd;
                r_arg         <= req_arg;
                r_idx         <= 2'd0;
                tx_byte_valid <= 1'b1;
                tx_byte       <= SYNC_REQ;
            end
            if (r_state == S_SEND && w_tx_hs) begin
                r_idx <= r_idx + 2'd1;
                if (r_idx == 2'd3)
                    tx_byte_valid <= 1'b0;
                else
                    tx_byte <= req_byte(r_idx + 2'd1, r_cmd, r_arg);
            end
            if (r_state == S_WAIT_HDR)
                r_bidx <= 2'd0;
            if (r_state == S_RX_BODY && rx_byte_valid) begin
                r_bidx <= r_bidx + 2'd1;
                unique case (r_bidx)
                    2'd0:    r_rx_cmd <= rx_byte;
                    2'd1:    r_rx_hi  <= rx_byte;
                    2'd2:    r_rx_lo  <= rx_byte;
                    default: ;
                endcase
            end
            if (w_rx_last) begin
                rsp_valid  <= 1'b1;
                rsp_cmd    <= r_rx_cmd;
                rsp_data   <= {r_rx_hi, r_rx_lo};
                rsp_status <= w_rx_status;
            end else if (w_timeout) begin
                rsp_valid  <= 1'b1;
                rsp_cmd    <= r_cmd;
                rsp_data   <= 16'h0000;
                rsp_status <= RSP_TIMEOUT;
            end
        end
    end

`ifdef BM1387_HOST_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_timeout_cnt <= 16'h0000;
            err_chk_cnt     <= 16'h0000;
        end else begin
            if (w_timeout && err_timeout_cnt != 16'hFFFF)
                err_timeout_cnt <= err_timeout_cnt + 16'd1;
            if (w_rx_last && w_chk_bad && err_chk_cnt != 16'hFFFF)
                err_chk_cnt <= err_chk_cnt + 16'd1;
        end
    end
`endif

endmodule
